// File: rtl/i_delay_serdes.sv
// Input delay line with saturating tap control feeding a bitslip-capable
// serial-to-parallel converter. The delay path free-runs; the deserializer
// only advances while EN and PLL_LOCK are both high.
module i_delay_serdes #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DELAY = 0
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic             I,
    input  logic             DLY_LOAD,
    input  logic             DLY_ADJ,
    input  logic             DLY_INCDEC,
    input  logic             EN,
    input  logic             BITSLIP_ADJ,
    input  logic             PLL_LOCK,
    output logic [5:0]       DLY_TAP_VALUE,
    output logic             O,
    output logic [WIDTH-1:0] Q,
    output logic             DATA_VALID
);

    localparam int unsigned TAP_W   = 6;
    localparam int unsigned DL_LEN  = 63;
    localparam int unsigned TAP_MAX = 63;
    localparam int unsigned CNT_W   = $clog2(WIDTH);

    // Reject illegal configurations while elaborating
    if (WIDTH < 3 || WIDTH > 10) begin : g_bad_width
        $fatal(1, "%m: illegal WIDTH=%0d (legal 3-10)", WIDTH);
    end
    if (DELAY > 63) begin : g_bad_delay
        $fatal(1, "%m: illegal DELAY=%0d (legal 0-63)", DELAY);
    end

    logic [DL_LEN-1:0] dl;
    logic [DL_LEN:0]   dl_ext;
    logic [TAP_W-1:0]  tap;
    logic              adj_q;
    logic              adj_rise;

    logic [WIDTH-2:0]  sr;
    logic [CNT_W-1:0]  cnt;
    logic              bs_q;
    logic              active;
    logic              slip;
    logic              last_bit;
    logic [WIDTH-1:0]  word;

    // Tap 0 selects the live input, tap k selects stage k-1
    assign dl_ext        = {dl, I};
    assign O             = dl_ext[tap];
    assign DLY_TAP_VALUE = tap;

    assign adj_rise = DLY_ADJ & ~adj_q;
    assign active   = EN & PLL_LOCK;
    assign slip     = active & BITSLIP_ADJ & ~bs_q;
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign word     = {sr, O};

    // Free-running delay line
    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            dl <= '0;
        end else begin
            dl <= {dl[DL_LEN-2:0], I};
        end
    end

    // Tap register: load has priority, adjust saturates at both ends
    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            tap   <= TAP_W'(DELAY);
            adj_q <= 1'b0;
        end else begin
            adj_q <= DLY_ADJ;
            if (DLY_LOAD) begin
                tap <= TAP_W'(DELAY);
            end else if (adj_rise) begin
                if (DLY_INCDEC) begin
                    if (tap != TAP_W'(TAP_MAX)) begin
                        tap <= tap + 1'b1;
                    end
                end else if (tap != '0) begin
                    tap <= tap - 1'b1;
                end
            end
        end
    end

    // Deserializer: a slip freezes the bit count for one clock so the
    // word boundary moves one bit later; going inactive drops the partial word
    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            sr         <= '0;
            cnt        <= '0;
            Q          <= '0;
            DATA_VALID <= 1'b0;
            bs_q       <= 1'b0;
        end else begin
            bs_q       <= BITSLIP_ADJ;
            DATA_VALID <= 1'b0;
            if (active) begin
                sr <= word[WIDTH-2:0];
                if (!slip) begin
                    if (last_bit) begin
                        Q          <= word;
                        cnt        <= '0;
                        DATA_VALID <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_i_delay_serdes.sv
// Bench for i_delay_serdes: two instances (DELAY=5 and DELAY=0) share one
// stimulus stream and are compared against a queue-based reference model.
module tb_i_delay_serdes;

    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst, i, load, adj, incdec, en, bs, lock;
    logic [5:0]   tap5, tap0;
    logic         o5, o0, dv5, dv0;
    logic [W-1:0] q5, q0;

    int checks   = 0;
    int failures = 0;

    // Reference model state; index 0 = DELAY 5 instance, 1 = DELAY 0 instance
    int m_tap [2];
    int m_cnt [2];
    int m_word[2];
    int m_q   [2];
    int m_dv  [2];
    int hq[$];
    bit m_adj_q, m_bs_q;

    typedef struct {
        logic         vi;
        logic [W-1:0] exp_q;
        logic         exp_dv;
    } vec_t;
    vec_t v22[8];

    always #5 clk = ~clk;

    i_delay_serdes #(.WIDTH(W), .DELAY(5)) u_d5 (
        .CLK_IN(clk), .RST(rst), .I(i), .DLY_LOAD(load), .DLY_ADJ(adj),
        .DLY_INCDEC(incdec), .EN(en), .BITSLIP_ADJ(bs), .PLL_LOCK(lock),
        .DLY_TAP_VALUE(tap5), .O(o5), .Q(q5), .DATA_VALID(dv5)
    );

    i_delay_serdes #(.WIDTH(W), .DELAY(0)) u_d0 (
        .CLK_IN(clk), .RST(rst), .I(i), .DLY_LOAD(load), .DLY_ADJ(adj),
        .DLY_INCDEC(incdec), .EN(en), .BITSLIP_ADJ(bs), .PLL_LOCK(lock),
        .DLY_TAP_VALUE(tap0), .O(o0), .Q(q0), .DATA_VALID(dv0)
    );

    function automatic int dly(int k);
        return (k == 0) ? 5 : 0;
    endfunction

    // Delayed output: tap 0 passes the live input, else the input seen tap clocks ago
    function automatic int model_o(int k, int cur_i);
        return (m_tap[k] == 0) ? cur_i : hq[m_tap[k] - 1];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hq.delete();
        for (int n = 0; n < 63; n++) hq.push_back(0);
        for (int k = 0; k < 2; k++) begin
            m_tap[k] = dly(k); m_cnt[k] = 0; m_word[k] = 0; m_q[k] = 0; m_dv[k] = 0;
        end
        m_adj_q = 1'b0;
        m_bs_q  = 1'b0;
    endtask

    // One rising edge of the model using the inputs currently applied
    task automatic model_clock();
        int o_pre[2];
        bit adj_rise, bs_rise, act;
        for (int k = 0; k < 2; k++) o_pre[k] = model_o(k, int'(i));
        adj_rise = adj && !m_adj_q;
        bs_rise  = bs && !m_bs_q;
        act      = en && lock;
        m_adj_q  = adj;
        m_bs_q   = bs;
        for (int k = 0; k < 2; k++) begin
            if (load) m_tap[k] = dly(k);
            else if (adj_rise) m_tap[k] = incdec ? ((m_tap[k] < 63) ? m_tap[k] + 1 : 63)
                                                 : ((m_tap[k] > 0) ? m_tap[k] - 1 : 0);
            m_dv[k] = 0;
            if (act) begin
                m_word[k] = ((m_word[k] << 1) | o_pre[k]) & ((1 << W) - 1);
                if (!bs_rise) begin
                    if (m_cnt[k] == int'(W) - 1) begin
                        m_q[k] = m_word[k]; m_cnt[k] = 0; m_dv[k] = 1;
                    end else begin
                        m_cnt[k]++;
                    end
                end
            end else begin
                m_cnt[k] = 0;
            end
        end
        hq.push_front(int'(i));
        void'(hq.pop_back());
    endtask

    task automatic drive(input logic vi, vload, vadj, vinc, ven, vbs, vlock);
        i = vi; load = vload; adj = vadj; incdec = vinc; en = ven; bs = vbs; lock = vlock;
    endtask

    task automatic pre_check();
        #1;
        check("o_d5", int'(o5), model_o(0, int'(i)));
        check("o_d0", int'(o0), model_o(1, int'(i)));
    endtask

    task automatic edge_check();
        @(posedge clk);
        model_clock();
        #1;
        check("q_d5",   int'(q5),   m_q[0]);
        check("dv_d5",  int'(dv5),  m_dv[0]);
        check("tap_d5", int'(tap5), m_tap[0]);
        check("q_d0",   int'(q0),   m_q[1]);
        check("dv_d0",  int'(dv0),  m_dv[1]);
        check("tap_d0", int'(tap0), m_tap[1]);
    endtask

    task automatic cycle(input logic vi, vload, vadj, vinc, ven, vbs, vlock);
        drive(vi, vload, vadj, vinc, ven, vbs, vlock);
        pre_check();
        edge_check();
    endtask

    // Reset asserted between clock edges; outputs must clear at once
    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_q_d5",   int'(q5),   0);
        check("rst_dv_d5",  int'(dv5),  0);
        check("rst_tap_d5", int'(tap5), 5);
        check("rst_o_d5",   int'(o5),   0);
        check("rst_q_d0",   int'(q0),   0);
        check("rst_dv_d0",  int'(dv0),  0);
        check("rst_tap_d0", int'(tap0), 0);
        check("rst_o_d0",   int'(o0),   int'(i));
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        v22[0] = '{1'b1, 4'h0, 1'b0};
        v22[1] = '{1'b0, 4'h0, 1'b0};
        v22[2] = '{1'b1, 4'h0, 1'b0};
        v22[3] = '{1'b1, 4'hB, 1'b1};
        v22[4] = '{1'b0, 4'hB, 1'b0};
        v22[5] = '{1'b0, 4'hB, 1'b0};
        v22[6] = '{1'b1, 4'hB, 1'b0};
        v22[7] = '{1'b0, 4'h2, 1'b1};

        // Basic deserialization from the table
        do_reset();
        for (int n = 0; n < 8; n++) begin
            cycle(v22[n].vi, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            check("v22_q",  int'(q0),  int'(v22[n].exp_q));
            check("v22_dv", int'(dv0), int'(v22[n].exp_dv));
        end

        // Single pulse through a 5-tap delay
        do_reset();
        for (int n = 0; n < 8; n++) begin
            drive(n == 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            pre_check();
            check("d5_pulse", int'(o5), (n == 5) ? 1 : 0);
            edge_check();
        end

        // Tap control: saturation, load priority, held adjust
        do_reset();
        for (int n = 0; n < 57; n++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        end
        check("tap_62", int'(tap5), 62);
        for (int n = 0; n < 3; n++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            check("tap_sat_hi", int'(tap5), 63);
            cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        check("tap_load", int'(tap5), 5);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("tap_load_adj", int'(tap5), 5);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 3; n++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("tap_held", int'(tap5), 6);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 7; n++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        end
        check("tap_sat_lo", int'(tap5), 0);

        // Bitslip on a repeating 1,0,0,0 stream with BITSLIP_ADJ held high
        do_reset();
        for (int n = 0; n < 20; n++) begin
            cycle((n % 4) == 0, 1'b0, 1'b0, 1'b0, 1'b1, n >= 8, 1'b1);
            check("slip_dv", int'(dv0), (n == 3 || n == 7 || n == 12 || n == 16) ? 1 : 0);
            if (n == 3 || n == 7)   check("slip_q_pre",  int'(q0), 8);
            if (n == 12 || n == 16) check("slip_q_post", int'(q0), 1);
        end

        // Lock dropped one clock after two bits of a word
        do_reset();
        for (int n = 0; n < 10; n++) begin
            cycle(1'($urandom_range(1)), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, n != 2);
            check("lock_dv", int'(dv0), (n == 6) ? 1 : 0);
        end

        // Reset mid-word after tap moved and Q loaded
        do_reset();
        for (int n = 0; n < 2; n++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        do_reset();
        check("rst_tap_back", int'(tap5), 5);
        for (int n = 0; n < 4; n++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            check("rst_first_word", int'(dv0), (n == 3) ? 1 : 0);
        end

        // Randomized traffic against the model, with occasional resets
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(399) == 0) do_reset();
            cycle(1'($urandom_range(1)), $urandom_range(29) == 0, $urandom_range(5) == 0,
                  1'($urandom_range(1)), $urandom_range(9) != 0, $urandom_range(7) == 0,
                  $urandom_range(9) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
